// File: rtl/ift_mem_responder.sv
// Word memory with a parallel per-bit taint array behind a req/gnt/rvalid port.
// Responses come back through a fixed-latency, in-order pipeline; grants can be periodically withheld.
module ift_mem_responder #(
  parameter int unsigned Depth          = 1 << 16,
  parameter logic [31:0] BaseAddr       = 32'h8000_0000,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned GntStallPeriod = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] strb_i,
  input  logic        req_i_t0,
  input  logic        we_i_t0,
  input  logic [31:0] addr_i_t0,
  input  logic [31:0] wdata_i_t0,
  input  logic [31:0] strb_i_t0,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] rdata_o_t0,
  output logic        err_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [31:0] taint;
    logic        err;
  } rsp_t;

  logic          stall;
  logic          accept;
  logic          ctl_t;
  logic          in_range;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          wr_en;
  rsp_t          stage0;
  rsp_t          pipe_q [ReadLatency];

  // Word storage is not reset; the taint array is 2-state so it starts clean.
  logic [31:0] mem       [Depth];
  bit   [31:0] taint_mem [Depth];

  // Periodic grant stall: counter advances on requesting cycles and wraps on the stall cycle.
  generate
    if (GntStallPeriod >= 2) begin : g_stall
      localparam int unsigned CntW = $clog2(GntStallPeriod);
      logic [CntW-1:0] cnt_q, cnt_d;

      assign stall = (cnt_q == CntW'(GntStallPeriod - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (req_i) begin
          cnt_d = stall ? '0 : cnt_q + CntW'(1);
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  assign gnt_o  = req_i & ~stall;
  assign accept = gnt_o;

  assign ctl_t    = req_i_t0 | we_i_t0 | (|addr_i_t0);
  assign offset   = addr_i - BaseAddr;
  assign in_range = (addr_i >= BaseAddr) && ((offset >> 2) < Depth);
  assign idx      = offset[AW+1:2];
  assign wr_en    = accept & we_i & in_range;

  // Unstrobed bits keep their data but still pick up strobe and control taint.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[idx]       <= (mem[idx] & ~strb_i) | (wdata_i & strb_i);
      taint_mem[idx] <= (taint_mem[idx] & ~strb_i) | (wdata_i_t0 & strb_i)
                        | strb_i_t0 | {32{ctl_t}};
    end
  end

  always_comb begin
    stage0       = '0;
    stage0.valid = accept;
    if (accept) begin
      if (!in_range) begin
        stage0.err   = 1'b1;
        stage0.taint = {32{ctl_t}};
      end else if (!we_i) begin
        stage0.data  = mem[idx];
        stage0.taint = ctl_t ? '1 : taint_mem[idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage0;
      for (int i = 1; i < ReadLatency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rvalid_o   = pipe_q[ReadLatency-1].valid;
  assign rdata_o    = pipe_q[ReadLatency-1].data;
  assign rdata_o_t0 = pipe_q[ReadLatency-1].taint;
  assign err_o      = pipe_q[ReadLatency-1].err;

endmodule

// File: tb/tb_ift_mem_responder.sv
// Bench for ift_mem_responder: two configurations checked every cycle against a
// queue-based reference model, plus directed cases with literal expectations.
module tb_ift_mem_responder;

  localparam logic [31:0] Base = 32'h8000_0000;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [31:0] t;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req, we, req_t, we_t;
  logic [31:0] addr [2], wdata [2], strb [2], addr_t [2], wdata_t [2], strb_t [2];
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata [2], rdata_t [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned k [2];
  logic [1:0] acc;
  exp_t rq [2][$];
  bit [31:0] m_data [longint];
  bit [31:0] m_taint [longint];
  logic ghist [$];
  logic [31:0] log_d [$];
  int log_c [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ift_mem_responder u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .strb_i(strb[0]), .req_i_t0(req_t[0]), .we_i_t0(we_t[0]),
    .addr_i_t0(addr_t[0]), .wdata_i_t0(wdata_t[0]), .strb_i_t0(strb_t[0]),
    .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .rdata_o_t0(rdata_t[0]),
    .err_o(err[0])
  );

  ift_mem_responder #(
    .Depth(256), .BaseAddr(Base), .ReadLatency(3), .GntStallPeriod(4)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .strb_i(strb[1]), .req_i_t0(req_t[1]), .we_i_t0(we_t[1]),
    .addr_i_t0(addr_t[1]), .wdata_i_t0(wdata_t[1]), .strb_i_t0(strb_t[1]),
    .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .rdata_o_t0(rdata_t[1]),
    .err_o(err[1])
  );

  function automatic int lat(input int n);
    return (n == 0) ? 1 : 3;
  endfunction
  function automatic int unsigned per(input int n);
    return (n == 0) ? 0 : 4;
  endfunction
  function automatic int unsigned dep(input int n);
    return (n == 0) ? 65536 : 256;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Reference behaviour of one accepted request, applied in arrival order.
  function automatic void model_access(input int n);
    logic [31:0] off, od, ot, nd, nt;
    bit inr, ctl;
    longint key;
    exp_t r;
    off = addr[n] - Base;
    inr = (addr[n] >= Base) && ((off >> 2) < dep(n));
    ctl = req_t[n] | we_t[n] | (|addr_t[n]);
    key = (longint'(n) << 32) | longint'(off >> 2);
    r.due = cyc + lat(n);
    r.d = 0; r.t = 0; r.e = 0;
    if (!inr) begin
      r.e = 1;
      r.t = {32{ctl}};
    end else if (we[n]) begin
      od = m_data.exists(key) ? m_data[key] : 0;
      ot = m_taint.exists(key) ? m_taint[key] : 0;
      for (int i = 0; i < 32; i++) begin
        if (strb[n][i]) begin
          nd[i] = wdata[n][i];
          nt[i] = wdata_t[n][i] | ctl | strb_t[n][i];
        end else begin
          nd[i] = od[i];
          nt[i] = ot[i] | strb_t[n][i] | ctl;
        end
      end
      m_data[key] = nd;
      m_taint[key] = nt;
    end else begin
      r.d = m_data.exists(key) ? m_data[key] : 0;
      r.t = ctl ? 32'hFFFF_FFFF : (m_taint.exists(key) ? m_taint[key] : 0);
    end
    rq[n].push_back(r);
  endfunction

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      exp_t r;
      logic eg;
      r.d = 0; r.t = 0; r.e = 0; r.due = 0;
      eg = 0;
      if (rst) rq[n].delete();
      if (rq[n].size() > 0 && rq[n][0].due == cyc) begin
        r = rq[n].pop_front();
        eg = 1;
      end
      chk("rvalid", 32'(rvalid[n]), 32'(eg));
      chk("rdata", rdata[n], r.d);
      chk("rdata_t0", rdata_t[n], r.t);
      chk("err", 32'(err[n]), 32'(r.e));
      if (rst) begin
        k[n] = 0;
        acc[n] = 1'b0;
        chk("gnt_rst", 32'(gnt[n]), 32'(req[n]));
      end else begin
        eg = req[n] && !(per(n) >= 2 && (k[n] % per(n)) == per(n) - 1);
        chk("gnt", 32'(gnt[n]), 32'(eg));
        acc[n] = eg;
        if (req[n]) k[n]++;
        if (eg) model_access(n);
      end
    end
    if (rvalid[1]) begin
      log_d.push_back(rdata[1]);
      log_c.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    req[n] = 0; we[n] = 0; req_t[n] = 0; we_t[n] = 0;
    addr[n] = 0; wdata[n] = 0; strb[n] = 0; addr_t[n] = 0; wdata_t[n] = 0; strb_t[n] = 0;
  endtask

  // Holds the request until the model grants it; returns 1ns after the grant edge.
  task automatic issue(input int n, input logic w, input logic [31:0] a, d, s,
                       input logic rt, wt, input logic [31:0] at, dt, st);
    req[n] = 1; we[n] = w; addr[n] = a; wdata[n] = d; strb[n] = s;
    req_t[n] = rt; we_t[n] = wt; addr_t[n] = at; wdata_t[n] = dt; strb_t[n] = st;
    for (int tries = 0; tries < 8; tries++) begin
      @(negedge clk);
      #1;
      ghist.push_back(gnt[n]);
      if (acc[n]) begin
        @(posedge clk);
        #1;
        idle(n);
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout inst %0d addr %h", n, a);
    idle(n);
  endtask

  task automatic wr(input int n, input logic [31:0] a, d, s, dt, at);
    issue(n, 1'b1, a, d, s, 1'b0, 1'b0, at, dt, 32'h0);
  endtask
  task automatic rd(input int n, input logic [31:0] a, at);
    issue(n, 1'b0, a, 32'h0, 32'h0, 1'b0, 1'b0, at, 32'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic random_phase(input int n, input int ops);
    logic [31:0] oor [4];
    logic [31:0] a, s;
    oor[0] = Base - 4; oor[1] = 32'h0; oor[2] = 32'hFFFF_FFFC; oor[3] = Base + 4 * dep(n);
    for (int i = 0; i < 16; i++) wr(n, Base + 4 * i, $urandom, 32'hFFFF_FFFF, 32'h0, 32'h0);
    for (int i = 0; i < ops; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        a = ($urandom_range(0, 7) == 0) ? oor[$urandom_range(0, 3)]
          : Base + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
        s = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
        issue(n, 1'($urandom_range(0, 1)), a, $urandom, s,
              $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
              ($urandom_range(0, 5) == 0) ? $urandom : 32'h0,
              ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
              ($urandom_range(0, 5) == 0) ? $urandom : 32'h0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(0);
    idle(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;

    // Write then read, latency 1.
    wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0);
    rd(0, 32'h8000_0010, 32'h0);
    chk("lit_rvalid", 32'(rvalid[0]), 32'h1);
    chk("lit_rdata", rdata[0], 32'hDEAD_BEEF);
    chk("lit_taint", rdata_t[0], 32'h0000_00FF);
    chk("lit_err", 32'(err[0]), 32'h0);

    // Partial strobe.
    wr(0, 32'h8000_0020, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    wr(0, 32'h8000_0020, 32'h0, 32'h0000_FFFF, 32'h0, 32'h0);
    rd(0, 32'h8000_0020, 32'h0);
    chk("lit_strb_data", rdata[0], 32'hFFFF_0000);
    chk("lit_strb_taint", rdata_t[0], 32'h0);

    // Tainted address.
    rd(0, 32'h8000_0020, 32'h4);
    chk("lit_ta_data", rdata[0], 32'hFFFF_0000);
    chk("lit_ta_taint", rdata_t[0], 32'hFFFF_FFFF);
    wr(0, 32'h8000_0030, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    wr(0, 32'h8000_0030, 32'h1, 32'h1, 32'h0, 32'h4);
    rd(0, 32'h8000_0030, 32'h0);
    chk("lit_taw_data", rdata[0], 32'h1);
    chk("lit_taw_taint", rdata_t[0], 32'hFFFF_FFFF);

    // Out of range; a wrapped index must not hit word 0.
    wr(0, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0);
    rd(0, 32'h7FFF_FFFC, 32'h0);
    chk("lit_oor_lo_err", 32'(err[0]), 32'h1);
    chk("lit_oor_lo_data", rdata[0], 32'h0);
    wr(0, 32'h8004_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    chk("lit_oor_wr_err", 32'(err[0]), 32'h1);
    rd(0, 32'h8004_0000, 32'h0);
    chk("lit_oor_hi_err", 32'(err[0]), 32'h1);
    rd(0, 32'h8000_0000, 32'h0);
    chk("lit_word0", rdata[0], 32'h1234_5678);
    chk("lit_word0_err", 32'(err[0]), 32'h0);

    // Latency 3 with periodic stall.
    for (int i = 0; i < 8; i++) wr(1, Base + 4 * i, 32'hA0 + i, 32'hFFFF_FFFF, 32'h0, 32'h0);
    pulse_reset();
    ghist.delete();
    log_d.delete();
    log_c.delete();
    for (int i = 0; i < 8; i++) rd(1, Base + 4 * i, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("lit_ghist_len", 32'(ghist.size()), 32'd10);
    if (ghist.size() == 10) begin
      chk("lit_gnt0", 32'(ghist[0]), 32'h1);
      chk("lit_gnt3", 32'(ghist[3]), 32'h0);
      chk("lit_gnt4", 32'(ghist[4]), 32'h1);
      chk("lit_gnt7", 32'(ghist[7]), 32'h0);
    end
    chk("lit_rsp_count", 32'(log_d.size()), 32'd8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("lit_rsp_order", log_d[i], 32'hA0 + i);
      chk("lit_rsp_gap01", 32'(log_c[1] - log_c[0]), 32'd1);
      chk("lit_rsp_gap23", 32'(log_c[3] - log_c[2]), 32'd2);
    end

    // Reset with two reads in flight.
    log_d.delete();
    rd(1, Base, 32'h0);
    rd(1, Base + 4, 32'h0);
    rst = 1;
    #1;
    chk("lit_rst_rvalid", 32'(rvalid[1]), 32'h0);
    chk("lit_rst_rdata", rdata[1], 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("lit_dropped", 32'(log_d.size()), 32'd0);
    ghist.delete();
    rd(1, Base + 8, 32'h0);
    chk("lit_post_rst_gnt", 32'(ghist[0]), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("lit_post_rst_rsp", (log_d.size() > 0) ? log_d[0] : 32'hX, 32'hA2);

    random_phase(0, 250);
    random_phase(1, 250);
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", 32'(rq[0].size() + rq[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ift_mem_responder.md
# ift_mem_responder

Taint-tracking memory responder for the Ibex tiny SoC. It sits on the memory-facing side of the core's instruction or data port (req/gnt/rvalid with bitwise strobe) and holds word storage plus a parallel per-bit taint array. Read data and read taint return after a configurable fixed latency. An optional periodic grant stall exercises the core's backpressure paths.

## Interface
- `Depth`, 1<<16: number of 32-bit words.
- `BaseAddr`, 32'h8000_0000: byte address of word 0.
- `ReadLatency`, 1: grant-to-rvalid cycles; legal range 1..4.
- `GntStallPeriod`, 0: 0 means never stall; N≥2 withholds the grant for one cycle in every N requesting cycles.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in 1: request valid.
- `we_i` in 1: write enable.
- `addr_i` in 32: byte address; bits [1:0] are ignored.
- `wdata_i` in 32: write data.
- `strb_i` in 32: bitwise write mask.
- `req_i_t0`, `we_i_t0` in 1; `addr_i_t0`, `wdata_i_t0`, `strb_i_t0` in 32: taints of the above.
- `gnt_o` out 1: request accepted this cycle.
- `rvalid_o` out 1: response valid, for both reads and writes.
- `rdata_o` out 32: read data.
- `rdata_o_t0` out 32: read data taint.
- `err_o` out 1: out-of-range access, valid with `rvalid_o`.

## Operation
- Index = (addr_i − BaseAddr) >> 2. The access is in range iff addr_i ≥ BaseAddr and index < Depth. Use 32-bit unsigned subtraction and compare before shifting.
- Grant: gnt_o = req_i & ~stall. The request is accepted on the rising edge where req_i & gnt_o = 1. At most one request is accepted per cycle; there is no outstanding limit.
- Stall counter (GntStallPeriod ≥ 2 only):
  - Increments on each cycle where req_i = 1.
  - stall = (cnt == GntStallPeriod−1).
  - On a stall cycle the counter wraps to 0.
  - When req_i = 0 the counter holds.
- Control taint: `ctl_t` = req_i_t0 | we_i_t0 | (|addr_i_t0).
- Accepted write, in range, per bit i with strb_i[i] = 1:
  - mem[i] ← wdata_i[i].
  - taint[i] ← wdata_i_t0[i] | ctl_t | strb_i_t0[i].
- Bits with strb_i[i] = 0 keep their data. Their taint becomes taint[i] | strb_i_t0[i] | ctl_t.
- Accepted read, in range: response data = mem[index]. Response taint = taint[index], or all ones if ctl_t = 1.
- Out of range: no storage change. Response has rdata 0, err 1, and rdata_t0 = {32{ctl_t}}.
- Write response: rdata_o = 0, rdata_o_t0 = 0, err_o = 0 unless out of range.
- Response pipeline:
  - ReadLatency stages of {valid, data, taint, err}.
  - Storage is read at the grant edge.
  - In-order, fully pipelined; back-to-back grants give back-to-back rvalids.
- Read-after-write: a read granted the cycle after a write to the same word returns the new data and taint.
- Reset clears the stall counter and all pipeline stages.
  - Storage and taint contents are not reset. The taint array is zero at simulation start.
  - In-flight responses are dropped.
  - A write granted on an edge before reset assertion stays committed.

## Timing
- Reset values: gnt_o follows req_i (combinational); rvalid_o 0, rdata_o 0, rdata_o_t0 0, err_o 0.
- gnt_o is combinational from req_i and the counter register. All other outputs are registered.
- Request granted at edge t → rvalid_o high during the cycle after edge t+ReadLatency−1. With ReadLatency = 1 this is the cycle immediately after the grant.
- Data-path outputs are 0 whenever rvalid_o = 0.
- Stall with period N under continuous req_i: the grant is low in cycles N−1, 2N−1, …, counted from 0 after reset.

## Test plan
- Write then read, ReadLatency=1: write 0x8000_0010 data 0xDEADBEEF, strb all ones, taint 0x0000_00FF. Read the same address next cycle → rvalid one cycle later, rdata 0xDEADBEEF, rdata_t0 0x0000_00FF, err 0.
- Partial strobe: pre-write 0xFFFF_FFFF (untainted), then write 0x0 with strb 0x0000_FFFF → read returns 0xFFFF_0000, taint 0.
- Tainted address: read in range with addr_i_t0 = 0x4 → rdata_t0 0xFFFF_FFFF, data correct. Tainted-address write of 0x1 with strb 0x1 → subsequent clean read shows taint 0xFFFF_FFFF.
- Out of range: read 0x7FFF_FFFC and BaseAddr+4·Depth → err 1, rdata 0. Storage at word 0 unchanged.
- ReadLatency=3, GntStallPeriod=4, 8 back-to-back reads of distinct words → grant low in cycles 3 and 7. Responses arrive in order, 3 cycles after each grant, with no gaps other than the stalls.
- Reset asserted with 2 reads in flight (ReadLatency=3) → rvalid never asserts for them; all outputs 0 during reset. The first post-reset request is granted normally and counts as stall-counter cycle 0.
